// File: rtl/divider.sv
// rtl/divider.sv - sequential restoring divider, one quotient bit per clock.
// Define DIVIDER_ZERO_CHK_EN for an early exit with the dz flag when b = 0.
module divider #(
  parameter int N = 4,
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic [M-1:0] r,
  output logic         dz
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   dvd;
  logic [M-1:0]   dvs;
  logic [M-1:0]   p;
  logic [N-2:0]   quot;
  logic [CW-1:0]  cnt;
  logic [M:0]     p_sh;
  logic [M+1:0]   trial;
  logic           qbit;
  logic [M:0]     p_nxt;
  logic [N-1:0]   quot_nxt;
  logic           accept;
  logic           zero_skip;

  assign accept = (state != RUN) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = zero_skip ? DONE : RUN;
      RUN:        if (cnt == '0) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // The partial remainder's top bit is always shifted out before it is read,
  // so only its low M bits are kept between iterations.
  always_comb begin
    p_sh     = {p, dvd[N-1]};
    trial    = {1'b0, p_sh} - {2'b00, dvs};
    qbit     = ~trial[M+1];
    p_nxt    = qbit ? trial[M:0] : p_sh;
    quot_nxt = {quot, qbit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd  <= '0;
      dvs  <= '0;
      p    <= '0;
      quot <= '0;
      cnt  <= '0;
      q    <= '0;
      r    <= '0;
    end else if (accept) begin
      dvd  <= a;
      dvs  <= b;
      p    <= '0;
      quot <= '0;
      cnt  <= CNT_LAST;
      if (zero_skip) begin
        q <= '1;
        r <= a[M-1:0];
      end
    end else if (state == RUN) begin
      dvd  <= {dvd[N-2:0], 1'b0};
      p    <= p_nxt[M-1:0];
      quot <= quot_nxt[N-2:0];
      cnt  <= cnt - CW'(1);
      if (cnt == '0) begin
        q <= quot_nxt;
        r <= p_nxt[M-1:0];
      end
    end
  end

`ifdef DIVIDER_ZERO_CHK_EN
  logic dz_q;

  assign zero_skip = (b == '0);
  assign dz        = dz_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dz_q <= 1'b0;
    end else if (accept) begin
      dz_q <= zero_skip;
    end
  end
`else
  assign zero_skip = 1'b0;
  assign dz        = 1'b0;
`endif

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed self-checking bench for the restoring divider.
module tb_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a_i;
  logic [1:0] b_i;
  logic       busy;
  logic       done;
  logic [3:0] q;
  logic [1:0] r;
  logic       dz;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divider #(.N(4), .M(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_i),
    .b     (b_i),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dz    (dz)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and waits for done; lat counts edges after the
  // accepting edge. With disturb set, start and operands wiggle while busy.
  task automatic run_op(input logic [3:0] ta, input logic [1:0] tbv,
                        input bit disturb, output int lat, output int bcnt);
    logic [3:0] q_prev;
    q_prev = q;
    a_i    = ta;
    b_i    = tbv;
    start  = 1'b1;
    tick();
    start = 1'b0;
    lat   = -1;
    bcnt  = 0;
    for (int i = 0; i < 12 && lat < 0; i++) begin
      if (done) begin
        lat   = i;
        start = 1'b0;
      end else begin
        if (busy) bcnt++;
        if (disturb) begin
          if (i == 1) check("hold_q", int'(q), int'(q_prev));
          start = i[0];
          a_i   = 4'hF;
          b_i   = 2'd1;
        end
        tick();
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, bcnt, since, idx, cyc;
    logic [3:0] cur_a;
    logic [1:0] cur_b;

    rst   = 1'b1;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_q", int'(q), 0);
    check("rst_r", int'(r), 0);
    check("rst_dz", int'(dz), 0);

    run_op(4'd13, 2'd3, 1'b0, lat, bcnt);
    check("13/3_lat", lat, 4);
    check("13/3_busy", bcnt, 4);
    check("13/3_q", int'(q), 4);
    check("13/3_r", int'(r), 1);

    // Back-to-back sweep with start held high.
    idx   = 0;
    cur_a = 4'd0;
    cur_b = 2'd1;
    a_i   = cur_a;
    b_i   = cur_b;
    start = 1'b1;
    tick();
    since = 0;
    cyc   = 0;
    while (idx < 48 && cyc < 48 * 8) begin
      cyc++;
      if (done) begin
        check("sweep_q", int'(q), int'(cur_a) / int'(cur_b));
        check("sweep_r", int'(r), int'(cur_a) % int'(cur_b));
        check("sweep_lat", since, 4);
        check("sweep_done_busy", int'(busy), 0);
        idx++;
        cur_a = 4'(idx / 3);
        cur_b = 2'(idx % 3 + 1);
        a_i   = cur_a;
        b_i   = cur_b;
        if (idx == 48) start = 1'b0;
        tick();
        since = 0;
      end else begin
        tick();
        since++;
      end
    end
    check("sweep_count", idx, 48);
    start = 1'b0;
    tick();

    run_op(4'd2, 2'd3, 1'b1, lat, bcnt);
    check("2/3_lat", lat, 4);
    check("2/3_q", int'(q), 0);
    check("2/3_r", int'(r), 2);
    run_op(4'd15, 2'd1, 1'b0, lat, bcnt);
    check("15/1_q", int'(q), 15);
    check("15/1_r", int'(r), 0);

    run_op(4'd9, 2'd0, 1'b0, lat, bcnt);
`ifdef DIVIDER_ZERO_CHK_EN
    check("9/0_lat", lat, 0);
    check("9/0_dz", int'(dz), 1);
`else
    check("9/0_lat", lat, 4);
    check("9/0_dz", int'(dz), 0);
`endif
    check("9/0_q", int'(q), 15);
    check("9/0_r", int'(r), 1);

    // Reset two cycles into RUN discards the operation.
    a_i   = 4'd14;
    b_i   = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", int'(busy), 0);
    check("mrst_done", int'(done), 0);
    check("mrst_q", int'(q), 0);
    check("mrst_r", int'(r), 0);
    check("mrst_dz", int'(dz), 0);
    run_op(4'd6, 2'd2, 1'b0, lat, bcnt);
    check("6/2_lat", lat, 4);
    check("6/2_q", int'(q), 3);
    check("6/2_r", int'(r), 0);

    // Reset wins over a simultaneous start.
    a_i   = 4'd7;
    b_i   = 2'd2;
    start = 1'b1;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy", int'(busy), 0);
    check("rst_start_q", int'(q), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Sequential restoring divider, the inverse companion of the team's 2×2 combinational multiplier. It divides an N-bit unsigned dividend by an M-bit unsigned divisor and produces one quotient bit per clock. A start/busy/done handshake lets a controller issue back-to-back operations. With the defaults (N=4, M=2), any 4-bit product from the multiplier divided by one of its 2-bit operands returns the other operand with remainder 0.

## Interface
- N, default 4: dividend and quotient width; must be ≥ 2.
- M, default 2: divisor and remainder width; must be ≥ 1 and ≤ N.
- clk  in  1: sole clock; everything is rising-edge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: request a division; sampled only when busy=0.
- a  in  N: dividend; captured on the accepting edge.
- b  in  M: divisor; captured on the accepting edge.
- busy  out  1: operation in progress; start is ignored while high.
- done  out  1: result valid; held until the next accepted start or reset.
- q  out  N: quotient.
- r  out  M: remainder.
- dz  out  1: divide-by-zero flag. Compiled in only with the configuration macro; otherwise tied to 0.

## Operation
- States:
  - IDLE: after reset.
  - RUN: iterating.
  - DONE: result held.
- IDLE/DONE with start=1 → RUN.
  - Latch a into the dividend shift register and b into the divisor register.
  - Clear the (M+1)-bit partial remainder.
  - Load the iteration counter with N-1.
  - Clear done.
- IDLE/DONE with start=0 → stay. Outputs hold.
- RUN, each edge:
  - Partial remainder p = {p[M-1:0], dividend MSB}; shift the dividend left.
  - Compute trial = p − {0,b}.
  - If trial is non-negative, p ← trial and the quotient bit = 1. Otherwise p is unchanged and the quotient bit = 0.
  - Quotient bits shift in MSB first.
  - Decrement the counter. When the counter is 0, go to DONE.
- Entry to DONE: q ← assembled quotient, r ← p[M-1:0], done ← 1.
- q and r change only on entry to DONE or on reset. They hold the previous result throughout RUN.
- Arithmetic is unsigned. p is M+1 bits, so the subtraction never overflows for b ≠ 0.
- b = 0 (natural restoring behaviour): every trial succeeds, giving q = all ones and r = a[M-1:0].
- Outputs are constrained to q ≤ a and r < b for b ≠ 0, with a = q·b + r exactly.
- start while busy=1 is ignored; a and b changes are ignored while busy.
- rst=1 at any edge, including mid-RUN:
  - Go to IDLE.
  - busy=0, done=0, q=0, r=0, dz=0.
  - Any in-flight operation is discarded.

## Timing
- Reset values: busy 0, done 0, q 0, r 0, dz 0. State is IDLE.
- Call the accepting edge E0.
- busy is 1 from after E0 through the edge that enters DONE.
- done rises after edge E0+N, so latency is N cycles (4 by default).
- Back-to-back: start=1 while done=1 is accepted on that edge.
  - done falls and busy rises in the next cycle.
  - Throughput is one result per N cycles.
- start held high continuously: a new operation begins on each DONE cycle, and done is high for exactly one cycle per result.
- rst and start on the same edge: reset wins.

## Configuration
- DIVIDER_ZERO_CHK_EN defined:
  - When b = 0 at the accepting edge, the block skips RUN and enters DONE on E0.
  - done is visible after 1 cycle with q = all ones, r = a[M-1:0], dz = 1.
  - dz clears on the next accepted start or on reset.
  - For b ≠ 0, dz = 0 and the N-cycle latency is unchanged.
- DIVIDER_ZERO_CHK_EN undefined:
  - No early exit; b = 0 takes the full N cycles and yields q = all ones, r = a[M-1:0].
  - dz is a constant 0.

## Test plan
- Reset then idle 5 cycles → busy=0, done=0, q=0, r=0, dz=0.
- a=13, b=3, start pulse → done after exactly 4 cycles, q=4, r=1. busy is high for exactly those 4 cycles.
- Exhaustive sweep: all a in 0..15, b in 1..3, issued back-to-back with start held high → each result satisfies a = q·b + r and r < b. One result every 4 cycles.
- a=2, b=3, then a=15, b=1 → q=0, r=2; then q=15, r=0. start pulses during busy are ignored, and a/b changes during busy are ignored.
- a=9, b=0:
  - With the macro → done after 1 cycle, q=15, r=1, dz=1.
  - Without the macro → done after 4 cycles, q=15, r=1, dz=0.
- a=14, b=3 started, rst asserted 2 cycles into RUN → all outputs return to reset values next cycle. A fresh a=6, b=2 then yields q=3, r=0.
